countdown_sequencer: RTL and testbench

Loadable N-bit down-counter with start/busy/done handshake. It is the consumer-side companion to the free-running enable-gated up-counter: a controller loads an iteration count, the block decrements it on each enable, and signals completion. It sits between the accelerator controller and the loop datapaths: window rows, filter taps and channel passes. Terminal detection, auto-reload and abort are handled here, so controllers only issue START and wait for DONE.

---
 rtl/accel_ctrl_pkg.sv | 15 +
 rtl/countdown_sequencer.sv | 117 +++++++++++
 tb/tb_countdown_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_ctrl_pkg.sv
// Shared definitions for the accelerator loop-control blocks.
//   state_t      : countdown sequencer state encoding
//   N_MIN, N_MAX : legal range of the counter width parameter
package accel_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COUNT  = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

endpackage

// File: rtl/countdown_sequencer.sv
// Loadable N-bit down-counter with start/busy/done handshake.
// A controller loads an iteration count with start, the block decrements on
// each en while counting, and pulses done on the terminal decrement.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   start    in   load request, accepted only while ready
//   load_val in   count to load (N bits)
//   en       in   decrement enable, effective only while counting
//   auto     in   reload from the reload register at the terminal decrement
//   abort    in   cancel a running count (no done)
//   dout     out  current count (registered)
//   ready    out  start can be accepted (IDLE or FINISH)
//   busy     out  counting
//   done     out  one-cycle completion pulse (registered)
//   last     out  combinational: counting and dout == 1
//
// state  | meaning
// IDLE   | waiting for start, dout = 0
// COUNT  | decrementing on en
// FINISH | single cycle after completion, done = 1, start may chain a run
module countdown_sequencer
    import accel_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         auto,
    input  logic         abort,
    output logic [N-1:0] dout,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         last
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [N-1:0] count, count_nxt;
    logic [N-1:0] reload, reload_nxt;
    logic         done_q, done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    if (load_val != '0) begin
                        count_nxt  = load_val;
                        reload_nxt = load_val;
                        state_nxt  = ST_COUNT;
                    end else begin
                        // zero-length run: report completion without counting
                        count_nxt = '0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_FINISH;
                    end
                end else if (state == ST_FINISH) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_COUNT: begin
                // abort takes priority over a coincident terminal decrement
                if (abort) begin
                    count_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (en) begin
                    if (count == ONE) begin
                        done_nxt = 1'b1;
                        if (auto) begin
                            count_nxt = reload;
                        end else begin
                            count_nxt = '0;
                            state_nxt = ST_FINISH;
                        end
                    end else begin
                        count_nxt = count - ONE;
                    end
                end
            end
            default: begin
                count_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dout  = count;
    assign done  = done_q;
    assign busy  = (state == ST_COUNT);
    assign ready = (state != ST_COUNT);
    assign last  = (state == ST_COUNT) && (count == ONE);

endmodule

// File: tb/tb_countdown_sequencer.sv
module tb_countdown_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] load_val;
    logic       en;
    logic       auto_r;
    logic       abort;
    logic [3:0] dout;
    logic       ready;
    logic       busy;
    logic       done;
    logic       last;

    int checks   = 0;
    int failures = 0;

    // reference model: a run is described by its period and the number of
    // EN-qualified cycles seen since the load
    bit m_run;
    bit m_done;
    int m_len;
    int m_ticks;

    typedef struct {
        logic       start;
        logic [3:0] load;
        logic       en;
        logic       au;
        logic       ab;
        logic [3:0] dout;
        logic       busy;
        logic       ready;
        logic       done;
        logic       last;
    } vec_t;

    vec_t vecs[$];

    countdown_sequencer #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .en       (en),
        .auto     (auto_r),
        .abort    (abort),
        .dout     (dout),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .last     (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_dout();
        return m_run ? (m_len - (m_ticks % m_len)) : 0;
    endfunction

    task automatic model_reset();
        m_run   = 0;
        m_done  = 0;
        m_len   = 1;
        m_ticks = 0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] lv, input logic e,
                              input logic a, input logic ab);
        if (m_run) begin
            if (ab) begin
                m_run  = 0;
                m_done = 0;
            end else if (e) begin
                m_ticks++;
                if (m_ticks % m_len == 0) begin
                    m_done = 1;
                    if (!a) m_run = 0;
                end else begin
                    m_done = 0;
                end
            end else begin
                m_done = 0;
            end
        end else begin
            if (s && lv != 0) begin
                m_len   = int'(lv);
                m_ticks = 0;
                m_run   = 1;
                m_done  = 0;
            end else begin
                m_done = s;
            end
        end
    endtask

    task automatic step(input logic s, input logic [3:0] lv, input logic e,
                        input logic a, input logic ab);
        start    = s;
        load_val = lv;
        en       = e;
        auto_r   = a;
        abort    = ab;
        @(posedge clk);
        model_edge(s, lv, e, a, ab);
        #1;
        chk("model_dout",  int'(dout),  exp_dout());
        chk("model_busy",  int'(busy),  int'(m_run));
        chk("model_ready", int'(ready), int'(!m_run));
        chk("model_done",  int'(done),  int'(m_done));
        chk("model_last",  int'(last),  int'(m_run && exp_dout() == 1));
    endtask

    task automatic add_vec(input logic s, input int lv, input logic e, input logic a,
                           input logic ab, input int d, input logic b, input logic r,
                           input logic dn, input logic l);
        vec_t v;
        v.start = s;  v.load = 4'(lv); v.en = e; v.au = a; v.ab = ab;
        v.dout  = 4'(d); v.busy = b; v.ready = r; v.done = dn; v.last = l;
        vecs.push_back(v);
    endtask

    initial begin
        int done_cnt;
        int done_at;
        bit busy_all;
        bit ok_pos;

        rst = 1'b1; start = 0; load_val = 0; en = 0; auto_r = 0; abort = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout",  int'(dout),  0);
        chk("reset_busy",  int'(busy),  0);
        chk("reset_ready", int'(ready), 1);
        chk("reset_done",  int'(done),  0);
        chk("reset_last",  int'(last),  0);
        rst = 1'b0;

        //      st ld en au ab  dout b r dn l
        add_vec(1, 5, 1, 0, 0,  5,   1,0,0, 0);
        add_vec(0, 0, 1, 0, 0,  4,   1,0,0, 0);
        add_vec(0, 0, 1, 0, 0,  3,   1,0,0, 0);
        add_vec(0, 0, 1, 0, 0,  2,   1,0,0, 0);
        add_vec(0, 0, 1, 0, 0,  1,   1,0,0, 1);
        add_vec(0, 0, 1, 0, 0,  0,   0,1,1, 0);
        add_vec(0, 0, 1, 0, 0,  0,   0,1,0, 0);
        add_vec(1, 0, 1, 0, 0,  0,   0,1,1, 0);
        add_vec(1, 2, 1, 0, 0,  2,   1,0,0, 0);
        add_vec(1, 9, 1, 0, 0,  1,   1,0,0, 1);
        add_vec(0, 0, 1, 0, 0,  0,   0,1,1, 0);
        add_vec(1, 3, 0, 0, 0,  3,   1,0,0, 0);
        add_vec(0, 0, 1, 0, 0,  2,   1,0,0, 0);
        add_vec(0, 0, 0, 0, 0,  2,   1,0,0, 0);
        add_vec(0, 0, 1, 0, 0,  1,   1,0,0, 1);
        add_vec(0, 0, 1, 0, 1,  0,   0,1,0, 0);
        add_vec(0, 0, 1, 0, 1,  0,   0,1,0, 0);
        add_vec(1, 3, 1, 1, 0,  3,   1,0,0, 0);
        add_vec(0, 0, 1, 1, 0,  2,   1,0,0, 0);
        add_vec(0, 0, 1, 1, 0,  1,   1,0,0, 1);
        add_vec(0, 0, 1, 1, 0,  3,   1,0,1, 0);
        add_vec(0, 0, 1, 1, 0,  2,   1,0,0, 0);
        add_vec(0, 0, 0, 1, 0,  2,   1,0,0, 0);
        add_vec(0, 0, 1, 1, 0,  1,   1,0,0, 1);
        add_vec(0, 0, 1, 0, 0,  0,   0,1,1, 0);
        add_vec(0, 0, 0, 0, 0,  0,   0,1,0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].load, vecs[i].en, vecs[i].au, vecs[i].ab);
            chk($sformatf("vec%0d_dout", i),  int'(dout),  int'(vecs[i].dout));
            chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(vecs[i].busy));
            chk($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].ready));
            chk($sformatf("vec%0d_done", i),  int'(done),  int'(vecs[i].done));
            chk($sformatf("vec%0d_last", i),  int'(last),  int'(vecs[i].last));
        end

        // AUTO run, L=3, nine EN cycles: done at cycles 2, 5, 8
        step(1, 3, 1, 1, 0);
        done_cnt = 0; busy_all = 1; ok_pos = 1;
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 1, 0);
            if (done) begin
                done_cnt++;
                if (i % 3 != 2) ok_pos = 0;
            end
            if (!busy) busy_all = 0;
        end
        chk("auto_done_count", done_cnt, 3);
        chk("auto_done_spacing", int'(ok_pos), 1);
        chk("auto_busy_held", int'(busy_all), 1);
        step(0, 0, 0, 0, 1);

        // L=4 with EN alternating 1,0,1,0 from the START cycle: done 8 edges later
        step(1, 4, 1, 0, 0);
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, (i % 2 == 0), 0, 0);
            if (done) begin
                done_at = i;
                break;
            end
        end
        chk("en_toggle_latency", done_at, 8);

        // asynchronous reset mid-count at dout=7
        step(1, 15, 1, 0, 0);
        repeat (8) step(0, 0, 1, 0, 0);
        chk("pre_rst_dout", int'(dout), 7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dout",  int'(dout),  0);
        chk("async_rst_busy",  int'(busy),  0);
        chk("async_rst_done",  int'(done),  0);
        chk("async_rst_ready", int'(ready), 1);
        rst = 1'b0;
        model_reset();
        step(1, 2, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("post_rst_done", int'(done), 1);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
